c0_vector_checker: RTL and testbench

- Sequential stimulus driver and response checker for the 14-in/12-out gate network top_c0. It sits at the opposite end of that interface.
- Drives an incrementing 14-bit vector onto the network input and waits a programmable settle time.
- Samples the 12-bit response and compares it against a built-in golden function.
- Reports mismatch count, first failing vector and a pass/done handshake.

---
 rtl/c0_vector_checker.sv | 170 +++++++++++++++++
 tb/tb_c0_vector_checker.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c0_vector_checker.sv
// ---------------------------------------------------------------------------
// c0_vector_checker
//
// Purpose:
//   Stimulus driver and response checker for the 14-in/12-out gate network
//   top_c0. A sweep applies every vector 0..VEC_LAST to the network input.
//   After each vector is applied it waits SETTLE cycles, then samples the
//   12-bit response and compares it against a built-in golden function.
//   Mismatches are counted in a saturating counter, and the first failing
//   vector is captured.
//
// Parameters:
//   SETTLE    cycles between a stim update and the response sample (1..15)
//   VEC_LAST  last vector applied; the sweep covers 0..VEC_LAST inclusive
//   CNT_W     width of err_count (the counter saturates at 2^CNT_W-1)
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   start            one-cycle pulse; begins a sweep when not busy
//   abort            stops a running sweep and returns to idle, done stays 0
//   stim[13:0]       vector driven onto the network input
//   resp[11:0]       network output being checked
//   busy             high from sweep start until the sweep ends or aborts
//   done             high once a sweep has finished; held until next start
//   pass             done with zero mismatches (combinational)
//   err_count        number of mismatching vectors, saturating
//   first_err_valid  set on the first mismatch of a sweep
//   first_err_vec    stim value of the first mismatch
// ---------------------------------------------------------------------------
module c0_vector_checker #(
  parameter int          SETTLE   = 1,
  parameter logic [13:0] VEC_LAST = 14'h3FFF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [13:0]      stim,
  input  logic [11:0]      resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [13:0]      first_err_vec
);

  // Sweep control states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Reload value for the settle counter; the legal SETTLE range fits 4 bits
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  localparam logic [CNT_W-1:0] ERR_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]  state;
  logic [3:0]  settle_cnt;
  logic [11:0] golden;
  logic        mismatch;
  logic        err_sat;
  logic        last_vec;

  // Expected network response for the vector currently on stim. Bits 0..9
  // come in pairs built from one input pair each (AND of the pair, then
  // inversion of the lower bit); the top two bits OR the upper input pairs.
  always_comb begin
    golden     = '0;
    golden[0]  = stim[0] & stim[1];
    golden[1]  = ~stim[0];
    golden[2]  = stim[2] & stim[3];
    golden[3]  = ~stim[2];
    golden[4]  = stim[4] & stim[5];
    golden[5]  = ~stim[4];
    golden[6]  = stim[6] & stim[7];
    golden[7]  = ~stim[6];
    golden[8]  = stim[8] & stim[9];
    golden[9]  = ~stim[8];
    golden[10] = stim[10] | stim[11];
    golden[11] = stim[12] | stim[13];
  end

  assign mismatch = (resp != golden);
  assign err_sat  = &err_count;
  assign last_vec = (stim == VEC_LAST);

  // pass is derived rather than registered, so it can never be high
  // while done is low.
  assign pass = done & (err_count == '0);

  // Sweep sequencer. A new sweep can be accepted from idle or from done;
  // start takes precedence over abort there because abort only matters
  // while a sweep is running. While running, abort beats the check action
  // so an aborted vector is never counted. The settle counter is loaded
  // with SETTLE and the check happens on the edge after it reads 1. This
  // gives each vector SETTLE wait cycles plus one check cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      settle_cnt      <= '0;
      stim            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            stim            <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            done            <= 1'b0;
            busy            <= 1'b1;
            settle_cnt      <= SETTLE_LD;
            state           <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (settle_cnt == 4'd1) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        ST_CHECK: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            if (mismatch) begin
              if (!err_sat) begin
                err_count <= err_count + ERR_ONE;
              end
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_vec   <= stim;
              end
            end
            if (last_vec) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              stim       <= stim + 14'd1;
              settle_cnt <= SETTLE_LD;
              state      <= ST_WAIT;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c0_vector_checker.sv
// ---------------------------------------------------------------------------
// tb_c0_vector_checker
//
// Purpose:
//   Self-checking bench for c0_vector_checker. The bench plays the role of
//   the gate network: it drives resp from stim through the golden function,
//   with an optional injected fault. The behavioural model predicts every
//   output from the number of edges elapsed since the sweep was accepted.
//   It uses a prefix count of faulty vectors. A compare process checks the
//   DUT against the model on every falling edge. Literal checks pin
//   individual results.
// ---------------------------------------------------------------------------
module tb_c0_vector_checker;

  localparam int          SETTLE   = 2;
  localparam logic [13:0] VEC_LAST = 14'h05FF;
  localparam int          CNT_W    = 8;

  localparam int NV    = int'(VEC_LAST) + 1;
  localparam int PER   = SETTLE + 1;
  localparam int END_N = NV * PER;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [13:0] stim;
    logic [31:0] err;
    logic        fvalid;
    logic [13:0] fvec;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [13:0]      stim;
  logic [11:0]      resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic             first_err_valid;
  logic [13:0]      first_err_vec;

  int total = 0;
  int bad   = 0;

  // fault_mode: 0 none, 1 stuck-at-0 on fault_bit, 2 fault_bit inverted,
  // 3 fault_bit inverted only on vector fault_vec
  int          fault_mode = 0;
  int          fault_bit  = 0;
  logic [13:0] fault_vec  = '0;

  int prefix [0:NV];
  int first_fault = NV;

  logic [31:0] m_n       = 0;
  logic        m_running = 1'b0;
  logic        m_done    = 1'b0;
  exp_t        m_hold    = '0;

  c0_vector_checker #(
    .SETTLE  (SETTLE),
    .VEC_LAST(VEC_LAST),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .stim           (stim),
    .resp           (resp),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_valid(first_err_valid),
    .first_err_vec  (first_err_vec)
  );

  always #5 clk = ~clk;

  // Golden function written pairwise: each of the five low input pairs
  // yields an AND bit followed by an inverted-lower-input bit.
  function automatic logic [11:0] golden_of(input logic [13:0] a);
    logic [11:0] g;
    g = '0;
    for (int p = 0; p < 5; p++) begin
      g[2*p]   = a[2*p] & a[2*p+1];
      g[2*p+1] = ~a[2*p];
    end
    g[10] = |a[11:10];
    g[11] = |a[13:12];
    return g;
  endfunction

  function automatic logic [11:0] faulty_of(input logic [13:0] a, input int mode,
                                            input int bitn, input logic [13:0] fv);
    logic [11:0] g;
    g = golden_of(a);
    case (mode)
      1: g[bitn] = 1'b0;
      2: g[bitn] = ~g[bitn];
      3: if (a == fv) g[bitn] = ~g[bitn];
      default: ;
    endcase
    return g;
  endfunction

  // Network emulation
  always_comb resp = faulty_of(stim, fault_mode, fault_bit, fault_vec);

  // Prefix count of vectors whose response differs from golden
  task automatic build_model();
    prefix[0]   = 0;
    first_fault = NV;
    for (int v = 0; v < NV; v++) begin
      logic [13:0] a;
      logic        diff;
      a    = 14'(v);
      diff = (faulty_of(a, fault_mode, fault_bit, fault_vec) != golden_of(a));
      prefix[v+1] = prefix[v] + (diff ? 1 : 0);
      if (diff && first_fault == NV) first_fault = v;
    end
  endtask

  // Outputs expected n edges after a sweep was accepted. Vector v is
  // checked on edge (v+1)*PER, so n/PER vectors have been checked so far.
  function automatic exp_t derive(input logic [31:0] n);
    exp_t e;
    int   checked;
    checked  = int'(n) / PER;
    if (checked > NV) checked = NV;
    e.stim   = (checked >= NV) ? VEC_LAST : 14'(checked);
    e.err    = (prefix[checked] > MAXC) ? 32'(MAXC) : 32'(prefix[checked]);
    e.fvalid = (first_fault < checked);
    e.fvec   = e.fvalid ? 14'(first_fault) : 14'h0;
    return e;
  endfunction

  // Model of the sweep timeline: counts edges while running and freezes
  // the prediction when the sweep completes or aborts.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_running <= 1'b0;
      m_done    <= 1'b0;
      m_n       <= 0;
      m_hold    <= '0;
    end else if (!m_running) begin
      if (start) begin
        m_running <= 1'b1;
        m_done    <= 1'b0;
        m_n       <= 0;
      end
    end else if (abort) begin
      m_hold    <= derive(m_n);
      m_running <= 1'b0;
    end else begin
      m_n <= m_n + 1;
      if (m_n + 1 == END_N) begin
        m_hold    <= derive(m_n + 1);
        m_running <= 1'b0;
        m_done    <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    exp_t e;
    e = m_running ? derive(m_n) : m_hold;
    checkOutput("stim", 32'(stim), 32'(e.stim));
    checkOutput("err_count", 32'(err_count), e.err);
    checkOutput("first_err_valid", 32'(first_err_valid), 32'(e.fvalid));
    checkOutput("first_err_vec", 32'(first_err_vec), 32'(e.fvec));
    checkOutput("busy", 32'(busy), 32'(m_running));
    checkOutput("done", 32'(done), 32'(m_done));
    checkOutput("pass", 32'(pass), 32'(m_done && e.err == 0));
  end

  // Configure the network fault, rebuild the model and pulse start
  task automatic applyStimulus(input int mode, input int bitn,
                               input logic [13:0] fv, input logic with_abort);
    @(negedge clk);
    fault_mode = mode;
    fault_bit  = bitn;
    fault_vec  = fv;
    build_model();
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Wait for done within a cycle budget, optionally poking start meanwhile
  task automatic wait_done(input logic poke, output int edges);
    edges = 0;
    while (!done && edges < END_N + 50) begin
      @(posedge clk);
      #1;
      edges++;
      start = poke && !done && ($urandom_range(0, 49) == 0);
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(done), 32'd1);
  endtask

  task automatic wait_stim(input logic [13:0] target);
    int cyc;
    cyc = 0;
    while (stim != target && cyc < END_N) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reach_stim", 32'(stim), 32'(target));
  endtask

  initial begin
    int edges;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    build_model();

    // Pin the golden model itself
    checkOutput("golden_0000", 32'(golden_of(14'h0000)), 32'h2AA);
    checkOutput("golden_3fff", 32'(golden_of(14'h3FFF)), 32'hD55);
    checkOutput("golden_0003", 32'(golden_of(14'h0003)), 32'h2A9);

    repeat (3) @(negedge clk);
    checkOutput("rst_stim", 32'(stim), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_err", 32'(err_count), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean sweep with stray start pulses while busy
    applyStimulus(0, 0, 14'h0, 1'b0);
    wait_done(1'b1, edges);
    checkOutput("clean_edges", 32'(edges), 32'd4608);
    checkOutput("clean_pass", 32'(pass), 32'd1);
    checkOutput("clean_stim_end", 32'(stim), 32'h5FF);
    checkOutput("clean_fvalid", 32'(first_err_valid), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("clean_stim_held", 32'(stim), 32'h5FF);

    // o[10] stuck at 0: fails from vector 0x400 on, 512 > 255 saturates
    applyStimulus(1, 10, 14'h0, 1'b0);
    checkOutput("model_o10_count", 32'(prefix[NV]), 32'd512);
    checkOutput("model_o10_first", 32'(first_fault), 32'h400);
    wait_done(1'b0, edges);
    checkOutput("o10_err", 32'(err_count), 32'd255);
    checkOutput("o10_fvec", 32'(first_err_vec), 32'h400);
    checkOutput("o10_pass", 32'(pass), 32'd0);

    // o[1] inverted: every vector fails, first one is 0
    applyStimulus(2, 1, 14'h0, 1'b0);
    wait_done(1'b0, edges);
    checkOutput("o1_err", 32'(err_count), 32'd255);
    checkOutput("o1_fvec", 32'(first_err_vec), 32'h0);
    checkOutput("o1_fvalid", 32'(first_err_valid), 32'd1);

    // Single random faulty vector
    begin
      logic [13:0] fv;
      fv = 14'($urandom_range(0, NV - 1));
      applyStimulus(3, int'($urandom_range(0, 11)), fv, 1'b0);
      wait_done(1'b0, edges);
      checkOutput("single_err", 32'(err_count), 32'd1);
      checkOutput("single_fvec", 32'(first_err_vec), 32'(fv));
    end

    // Fully random fault configuration, model-checked only
    applyStimulus(int'($urandom_range(1, 3)), int'($urandom_range(0, 11)),
                  14'($urandom_range(0, NV - 1)), 1'b0);
    wait_done(1'b0, edges);

    // Asynchronous reset in the middle of a sweep
    applyStimulus(2, 3, 14'h0, 1'b0);
    wait_stim(14'h0100);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_stim", 32'(stim), 32'h0);
    checkOutput("arst_busy", 32'(busy), 32'h0);
    checkOutput("arst_err", 32'(err_count), 32'h0);
    checkOutput("arst_fvalid", 32'(first_err_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(3, 5, 14'h0123, 1'b0);
    checkOutput("restart_stim", 32'(stim), 32'h0);
    checkOutput("restart_err", 32'(err_count), 32'h0);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    wait_done(1'b0, edges);
    checkOutput("restart_edges", 32'(edges), 32'd4608);

    // Abort at vector 0x20 with o[11] inverted (every vector fails)
    applyStimulus(2, 11, 14'h0, 1'b0);
    wait_stim(14'h0020);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_err", 32'(err_count), 32'd32);
    checkOutput("abort_stim", 32'(stim), 32'h20);
    repeat (5) @(negedge clk);
    checkOutput("abort_idle", 32'(busy), 32'd0);

    // Start and abort together from idle: start wins
    applyStimulus(0, 0, 14'h0, 1'b1);
    checkOutput("startwin_busy", 32'(busy), 32'd1);
    checkOutput("startwin_err", 32'(err_count), 32'd0);
    wait_done(1'b0, edges);
    checkOutput("after_abort_pass", 32'(pass), 32'd1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
